// File: rtl/clock_timekeeper.sv
// clock_timekeeper: BCD time-of-day counter with button-driven set mode and blinking field enables
module clock_timekeeper #(
   parameter logic [7:0] INIT_HH = 8'h00,
   parameter logic [7:0] INIT_MM = 8'h00,
   parameter logic [7:0] INIT_SS = 8'h00
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clk_1hz_tick,
   input  logic       blink_toggle,
   input  logic       btn_mode,
   input  logic       btn_inc,
   output logic [7:0] hh_bcd,
   output logic [7:0] mm_bcd,
   output logic [7:0] ss_bcd,
   output logic [5:0] digit_en,
   output logic [1:0] mode,
   output logic       day_wrap
);
   typedef enum logic [1:0] {RUN = 2'd0, SET_HH = 2'd1, SET_MM = 2'd2, SET_SS = 2'd3} state_t;
   state_t state, state_nx;
   logic [7:0] hh_nx, mm_nx, ss_nx;
   logic run_tick, set_inc, wrap_nx;
   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
      return (v == top) ? 8'h00 : (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
   endfunction
   always_comb begin
      run_tick = (state == RUN) && clk_1hz_tick;
      set_inc  = (state != RUN) && btn_inc && !btn_mode;
      ss_nx    = (run_tick || (set_inc && state == SET_SS)) ? bcd_inc(ss_bcd, 8'h59) : ss_bcd;
      mm_nx    = ((run_tick && ss_bcd == 8'h59) || (set_inc && state == SET_MM)) ? bcd_inc(mm_bcd, 8'h59) : mm_bcd;
      hh_nx    = ((run_tick && ss_bcd == 8'h59 && mm_bcd == 8'h59) || (set_inc && state == SET_HH)) ? bcd_inc(hh_bcd, 8'h23) : hh_bcd;
      wrap_nx  = run_tick && hh_bcd == 8'h23 && mm_bcd == 8'h59 && ss_bcd == 8'h59;
      state_nx = btn_mode ? state_t'(state + 2'd1) : state;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= RUN;
         hh_bcd   <= INIT_HH;
         mm_bcd   <= INIT_MM;
         ss_bcd   <= INIT_SS;
         day_wrap <= 1'b0;
      end else begin
         state    <= state_nx;
         hh_bcd   <= hh_nx;
         mm_bcd   <= mm_nx;
         ss_bcd   <= ss_nx;
         day_wrap <= wrap_nx;
      end
   end
   assign mode     = state;
   assign digit_en = {(state == SET_HH) ? {2{blink_toggle}} : 2'b11,
                      (state == SET_MM) ? {2{blink_toggle}} : 2'b11,
                      (state == SET_SS) ? {2{blink_toggle}} : 2'b11};
endmodule

// File: tb/tb_clock_timekeeper.sv
// tb_clock_timekeeper: vector table, directed corner cases and random run against a seconds-of-day model
module tb_clock_timekeeper;
   logic clk = 1'b0, rst = 1'b1, clk_1hz_tick = 1'b0, blink_toggle = 1'b0, btn_mode = 1'b0, btn_inc = 1'b0;
   logic [7:0] hh_bcd, mm_bcd, ss_bcd;
   logic [5:0] digit_en;
   logic [1:0] mode;
   logic day_wrap;
   int tests = 0, fails = 0;

   clock_timekeeper dut (
      .clk(clk), .rst(rst), .clk_1hz_tick(clk_1hz_tick), .blink_toggle(blink_toggle),
      .btn_mode(btn_mode), .btn_inc(btn_inc), .hh_bcd(hh_bcd), .mm_bcd(mm_bcd), .ss_bcd(ss_bcd),
      .digit_en(digit_en), .mode(mode), .day_wrap(day_wrap)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic tick, blink, bm, bi;
      logic [7:0] hh, mm, ss;
      logic [1:0] md;
      logic [5:0] en;
      logic wrap;
   } vec_t;
   vec_t tbl[12];

   task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got %h expected %h", n, a, e);
      end
   endtask

   task automatic chk_all(input string n, input logic [7:0] h, m, s, input logic [1:0] md, input logic [5:0] en, input logic w);
      chk({n, " hh"}, hh_bcd, h);
      chk({n, " mm"}, mm_bcd, m);
      chk({n, " ss"}, ss_bcd, s);
      chk({n, " mode"}, {6'd0, mode}, {6'd0, md});
      chk({n, " digit_en"}, {2'd0, digit_en}, {2'd0, en});
      chk({n, " day_wrap"}, {7'd0, day_wrap}, {7'd0, w});
   endtask

   task automatic pulse(input logic t, input logic m, input logic i);
      clk_1hz_tick = t; btn_mode = m; btn_inc = i;
      @(posedge clk); #1;
      clk_1hz_tick = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
   endtask

   task automatic do_reset();
      clk_1hz_tick = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0; blink_toggle = 1'b0;
      #2 rst = 1'b1;
      #3 rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic set_time(input int h, input int m, input int s);
      do_reset();
      pulse(0, 1, 0);
      repeat (h) pulse(0, 0, 1);
      pulse(0, 1, 0);
      repeat (m) pulse(0, 0, 1);
      pulse(0, 1, 0);
      repeat (s) pulse(0, 0, 1);
      pulse(0, 1, 0);
   endtask

   function automatic logic [7:0] bcd(input int v);
      return 8'(((v / 10) << 4) | (v % 10));
   endfunction

   initial begin
      int mh, mm_, ms, md, secs;
      logic t, b, m, i, ew, wrap_seen;
      tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 2'd1, 6'b001111, 1'b0};
      tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 2'd1, 6'b111111, 1'b0};
      tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 8'h00, 8'h00, 2'd1, 6'b001111, 1'b0};
      tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h02, 8'h00, 8'h00, 2'd1, 6'b111111, 1'b0};
      tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h02, 8'h00, 8'h00, 2'd2, 6'b110011, 1'b0};
      tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h02, 8'h01, 8'h00, 2'd2, 6'b110011, 1'b0};
      tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h02, 8'h01, 8'h00, 2'd3, 6'b111100, 1'b0};
      tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h02, 8'h01, 8'h01, 2'd3, 6'b111111, 1'b0};
      tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h02, 8'h01, 8'h01, 2'd0, 6'b111111, 1'b0};
      tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h02, 8'h01, 8'h02, 2'd0, 6'b111111, 1'b0};
      tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h02, 8'h01, 8'h03, 2'd1, 6'b111111, 1'b0};
      tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h03, 8'h01, 8'h03, 2'd1, 6'b001111, 1'b0};

      #12;
      chk_all("reset hold", 8'h00, 8'h00, 8'h00, 2'd0, 6'h3F, 1'b0);
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #1 chk_all("after reset idle", 8'h00, 8'h00, 8'h00, 2'd0, 6'h3F, 1'b0);

      for (int k = 0; k < 12; k++) begin
         blink_toggle = tbl[k].blink;
         pulse(tbl[k].tick, tbl[k].bm, tbl[k].bi);
         chk_all($sformatf("vec%0d", k), tbl[k].hh, tbl[k].mm, tbl[k].ss, tbl[k].md, tbl[k].en, tbl[k].wrap);
      end

      set_time(0, 9, 59);
      pulse(1, 0, 0);
      chk_all("carry 00:09:59", 8'h00, 8'h10, 8'h00, 2'd0, 6'h3F, 1'b0);
      set_time(9, 59, 59);
      pulse(1, 0, 0);
      chk_all("carry 09:59:59", 8'h10, 8'h00, 8'h00, 2'd0, 6'h3F, 1'b0);

      set_time(23, 59, 58);
      pulse(1, 0, 0);
      chk_all("roll step1", 8'h23, 8'h59, 8'h59, 2'd0, 6'h3F, 1'b0);
      pulse(1, 0, 0);
      chk_all("roll step2", 8'h00, 8'h00, 8'h00, 2'd0, 6'h3F, 1'b1);
      pulse(0, 0, 0);
      chk("roll wrap drop", {7'd0, day_wrap}, 8'h00);

      do_reset();
      pulse(0, 1, 0);
      chk("set mode", {6'd0, mode}, 8'h01);
      repeat (5) pulse(1, 0, 0);
      chk_all("frozen", 8'h00, 8'h00, 8'h00, 2'd1, 6'b001111, 1'b0);
      wrap_seen = 1'b0;
      for (int k = 0; k < 25; k++) begin
         pulse(0, 0, 1);
         wrap_seen |= day_wrap;
      end
      chk_all("25 inc", 8'h01, 8'h00, 8'h00, 2'd1, 6'b001111, 1'b0);
      chk("25 inc no wrap", {7'd0, wrap_seen}, 8'h00);
      blink_toggle = 1'b1;
      #1 chk("blink hi", {2'd0, digit_en}, 8'h3F);
      blink_toggle = 1'b0;
      #1 chk("blink lo", {2'd0, digit_en}, 8'h0F);

      set_time(0, 0, 5);
      pulse(1, 1, 0);
      chk_all("tick+mode", 8'h00, 8'h00, 8'h06, 2'd1, 6'b001111, 1'b0);

      do_reset();
      repeat (3) pulse(0, 1, 0);
      repeat (42) pulse(0, 0, 1);
      chk("set ss 42", ss_bcd, 8'h42);
      #2 rst = 1'b1;
      #1 chk_all("async reset", 8'h00, 8'h00, 8'h00, 2'd0, 6'h3F, 1'b0);
      #1 rst = 1'b0;

      do_reset();
      mh = 0; mm_ = 0; ms = 0; md = 0;
      for (int k = 0; k < 4000; k++) begin
         t = ($urandom % 3) == 0;
         b = $urandom % 2;
         m = ($urandom % 12) == 0;
         i = ($urandom % 3) == 0;
         blink_toggle = b;
         pulse(t, m, i);
         ew = 1'b0;
         if (md == 0 && t) begin
            secs = mh * 3600 + mm_ * 60 + ms;
            ew = secs == 86399;
            secs = (secs + 1) % 86400;
            mh = secs / 3600; mm_ = (secs / 60) % 60; ms = secs % 60;
         end else if (md != 0 && i && !m) begin
            if (md == 1) mh = (mh + 1) % 24;
            else if (md == 2) mm_ = (mm_ + 1) % 60;
            else ms = (ms + 1) % 60;
         end
         if (m) md = (md + 1) % 4;
         chk_all($sformatf("rand%0d", k), bcd(mh), bcd(mm_), bcd(ms), 2'(md),
                 {md == 1 ? {2{b}} : 2'b11, md == 2 ? {2{b}} : 2'b11, md == 3 ? {2{b}} : 2'b11}, ew);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/clock_timekeeper.md
# clock_timekeeper

Time-of-day core for the digital clock, directly downstream of the clock divider. It counts hours, minutes and seconds in BCD on each 1 Hz tick and provides a button-driven set mode. In set mode the selected field blinks using the divider's 2 Hz blink level. Outputs feed the seven-segment display driver.

## Interface
- `INIT_HH`, default `8'h00`: BCD hour loaded on reset; must be ≤ `8'h23`.
- `INIT_MM`, default `8'h00`: BCD minute loaded on reset; must be ≤ `8'h59`.
- `INIT_SS`, default `8'h00`: BCD second loaded on reset; must be ≤ `8'h59`.

- `clk`  in  1  system clock; the single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `clk_1hz_tick`  in  1  single-cycle pulse, once per second, from the divider.
- `blink_toggle`  in  1  2 Hz, 50 % duty level from the divider.
- `btn_mode`  in  1  single-cycle pulse, already debounced; advances the mode.
- `btn_inc`  in  1  single-cycle pulse, already debounced; increments the selected field.
- `hh_bcd`  out  8  hours, BCD, {tens, ones}.
- `mm_bcd`  out  8  minutes, BCD.
- `ss_bcd`  out  8  seconds, BCD.
- `digit_en`  out  6  per-digit display enables: [5:4] HH, [3:2] MM, [1:0] SS; 1 = lit.
- `mode`  out  2  current state code.
- `day_wrap`  out  1  single-cycle pulse on the 23:59:59 → 00:00:00 rollover.

## Operation
- FSM states and codes: RUN = 0, SET_HH = 1, SET_MM = 2, SET_SS = 3.
- State transitions on `btn_mode`: RUN → SET_HH → SET_MM → SET_SS → RUN. No other transitions.
- `mode` is the registered state code.
- RUN:
  - On `clk_1hz_tick`, seconds increment with full BCD carry.
  - Ones digit wraps 9 → 0 and increments the tens digit.
  - SS wraps 59 → 00 and carries into MM; MM wraps 59 → 00 and carries into HH; HH wraps 23 → 00.
  - `btn_inc` is ignored.
- SET_x:
  - `clk_1hz_tick` is ignored; time is frozen.
  - `btn_inc` increments only the selected field.
  - HH wraps 23 → 00; MM and SS wrap 59 → 00.
  - No carry into other fields, and no `day_wrap`.
- Simultaneous `btn_mode` and `btn_inc`: the mode change takes effect and the increment is dropped.
- Simultaneous `clk_1hz_tick` and `btn_mode` in RUN: the tick is applied, and the state becomes SET_HH in the same clock edge.
- Field registers always hold legal BCD values. Digit values A–F never occur.
- `digit_en`:
  - All ones in RUN.
  - In SET_x, the two bits of the selected field equal `blink_toggle`; all other bits are 1.
- `day_wrap` asserts only for a RUN-mode tick that takes the time from 23:59:59 to 00:00:00.

## Timing
- Reset (asynchronous, while `rst` = 1):
  - HH/MM/SS = INIT values.
  - `mode` = 0 (RUN).
  - `day_wrap` = 0.
  - `digit_en` = `6'b111111`.
- Reset asserted mid-set returns the block immediately to RUN with the INIT time.
- Time outputs and `mode` are registered: they update on the rising edge on which the input pulse is sampled, so they are visible one cycle after the pulse.
- `day_wrap` is registered. It is high for exactly the one cycle in which the outputs first show 00:00:00.
- `digit_en` is combinational from the registered state and `blink_toggle`, with zero latency from `blink_toggle`.
- Every input pulse is acted on exactly once per high cycle. A multi-cycle high on an input counts as one event per cycle.

## Test plan
- Reset: hold `rst` = 1 with default parameters → outputs 00:00:00, `mode` = 0, `digit_en` = `6'h3F`, `day_wrap` = 0. Release reset with no ticks → values hold.
- BCD carry: starting from 00:09:59 in RUN, apply one tick → 00:10:00. Then, starting from 09:59:59, apply one tick → 10:00:00. `day_wrap` stays 0 in both cases.
- Day rollover:
  - Set the time to 23:59:58, return to RUN, apply one tick → 23:59:59.
  - Apply a second tick → 00:00:00, with `day_wrap` high for exactly 1 cycle.
- Set mode:
  - One `btn_mode` pulse → `mode` = 1. Apply 5 ticks → time unchanged.
  - 25 `btn_inc` pulses starting from HH 00 → HH = 01, MM/SS unchanged, `day_wrap` never asserted.
  - `digit_en[5:4]` tracks `blink_toggle`; `digit_en[3:0]` = `4'hF`.
- Collisions:
  - In SET_MM, pulse `btn_mode` and `btn_inc` together → `mode` = 3, MM unchanged.
  - In RUN at 00:00:05, pulse a tick and `btn_mode` together → SS = 06 and `mode` = 1.
- Reset mid-operation: in SET_SS with SS = 42, assert `rst` asynchronously between clock edges → outputs return immediately to INIT values, `mode` = 0, `digit_en` = `6'h3F`.
